// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: PS/2 set-2 scan codes, joystick bit
// positions, the per-player key latch layout and the control-rotation helper.
package arcade_input_pkg;

   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_CTRL  = 8'h14;
   localparam logic [7:0] KEY_1     = 8'h16;
   localparam logic [7:0] KEY_F1    = 8'h05;
   localparam logic [7:0] KEY_5     = 8'h2E;
   localparam logic [7:0] KEY_R     = 8'h2D;
   localparam logic [7:0] KEY_F     = 8'h2B;
   localparam logic [7:0] KEY_D     = 8'h23;
   localparam logic [7:0] KEY_G     = 8'h34;
   localparam logic [7:0] KEY_A     = 8'h1C;
   localparam logic [7:0] KEY_2     = 8'h1E;
   localparam logic [7:0] KEY_F2    = 8'h06;
   localparam logic [7:0] KEY_6     = 8'h36;

   localparam int unsigned JOY_R     = 0;
   localparam int unsigned JOY_L     = 1;
   localparam int unsigned JOY_D     = 2;
   localparam int unsigned JOY_U     = 3;
   localparam int unsigned JOY_FIRE  = 4;
   localparam int unsigned JOY_START = 5;
   localparam int unsigned JOY_COIN  = 6;

   // Function a scan code maps to; the player is carried separately.
   typedef enum logic [3:0] {
      KeyNone,
      KeyUp,
      KeyDown,
      KeyLeft,
      KeyRight,
      KeyFireA,
      KeyFireB,
      KeyStartA,
      KeyStartB,
      KeyCoin
   } key_fn_t;

   // Two fire and two start bits so that two keys sharing a function release independently.
   typedef struct packed {
      logic u;
      logic d;
      logic l;
      logic r;
      logic fire_a;
      logic fire_b;
      logic start_a;
      logic start_b;
      logic coin;
   } key_set_t;

   // dirs is {R,L,D,U}; cw=0: U<-L, D<-R, L<-D, R<-U; cw=1: the opposite sense.
   function automatic logic [3:0] rotate_dirs(input logic [3:0] dirs, input logic cw);
      logic [3:0] res;
      if (cw) res = {dirs[1], dirs[0], dirs[2], dirs[3]};
      else    res = {dirs[0], dirs[1], dirs[3], dirs[2]};
      return res;
   endfunction

endpackage

// File: rtl/input_pulse_stretch.sv
// Turns the rising edge of a request into a pulse exactly CYCLES clocks wide; edges
// arriving while a pulse is in flight are dropped and a held request never retriggers.
module input_pulse_stretch #(
   parameter int unsigned CYCLES = 120000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic req,
   output logic pulse
);

   localparam int unsigned CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(CYCLES);

   logic          req_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          pulse_q;

   // Loads only from zero and stops at zero, so the counter can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else if (req && !req_q) begin
         cnt_d = LOAD;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         req_q   <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         req_q   <= req;
         cnt_q   <= cnt_d;
         pulse_q <= (cnt_d != '0);
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick to cabinet input mapper: latches PS/2 key state per player, merges
// joystick words, optionally rotates directions and drives registered, polarity-adjusted outputs.
module arcade_input_mapper
   import arcade_input_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS       = 2,
   parameter int unsigned COIN_PULSE_CYCLES = 120000,
   parameter int unsigned ACTIVE_LOW        = 1,
   parameter int unsigned START_IS_COIN     = 1,
   parameter int unsigned ROT_CW            = 0
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic [10:0]                ps2_key,
   input  logic [16*NUM_PLAYERS-1:0]  joystick,
   input  logic                       rotate,
   output logic [4*NUM_PLAYERS-1:0]   dirs_o,
   output logic [NUM_PLAYERS-1:0]     fire_o,
   output logic [NUM_PLAYERS-1:0]     start_o,
   output logic [NUM_PLAYERS-1:0]     coin_o
);

   localparam logic POL = (ACTIVE_LOW != 0);
   localparam logic CW_SENSE = (ROT_CW != 0);
   localparam logic HAS_P1 = (NUM_PLAYERS > 1);

   logic     shadow_q;
   logic     key_event;
   logic     key_ext;
   logic     key_pressed;
   logic [7:0] key_code;
   key_fn_t  key_fn;
   logic     key_pl;

   key_set_t [1:0] key_q;
   key_set_t [1:0] key_d;

   logic [4*NUM_PLAYERS-1:0] dirs_next;
   logic [NUM_PLAYERS-1:0]   fire_next;
   logic [NUM_PLAYERS-1:0]   start_next;
   logic [NUM_PLAYERS-1:0]   coin_req;
   logic [NUM_PLAYERS-1:0]   coin_pulse;

   logic [4*NUM_PLAYERS-1:0] dirs_q;
   logic [NUM_PLAYERS-1:0]   fire_q;
   logic [NUM_PLAYERS-1:0]   start_q;

   assign key_event   = (shadow_q != ps2_key[10]);
   assign key_pressed = ps2_key[9];
   assign key_ext     = ps2_key[8];
   assign key_code    = ps2_key[7:0];

   // Arrows accept either prefix state; every other code must arrive unextended.
   always_comb begin
      key_fn = KeyNone;
      key_pl = 1'b0;
      case (key_code)
         KEY_UP:    key_fn = KeyUp;
         KEY_DOWN:  key_fn = KeyDown;
         KEY_LEFT:  key_fn = KeyLeft;
         KEY_RIGHT: key_fn = KeyRight;
         KEY_SPACE: if (!key_ext) key_fn = KeyFireA;
         KEY_CTRL:  if (!key_ext) key_fn = KeyFireB;
         KEY_1:     if (!key_ext) key_fn = KeyStartA;
         KEY_F1:    if (!key_ext) key_fn = KeyStartB;
         KEY_5:     if (!key_ext) key_fn = KeyCoin;
         KEY_R: if (!key_ext && HAS_P1) begin key_fn = KeyUp;     key_pl = 1'b1; end
         KEY_F: if (!key_ext && HAS_P1) begin key_fn = KeyDown;   key_pl = 1'b1; end
         KEY_D: if (!key_ext && HAS_P1) begin key_fn = KeyLeft;   key_pl = 1'b1; end
         KEY_G: if (!key_ext && HAS_P1) begin key_fn = KeyRight;  key_pl = 1'b1; end
         KEY_A: if (!key_ext && HAS_P1) begin key_fn = KeyFireA;  key_pl = 1'b1; end
         KEY_2: if (!key_ext && HAS_P1) begin key_fn = KeyStartA; key_pl = 1'b1; end
         KEY_F2: if (!key_ext && HAS_P1) begin key_fn = KeyStartB; key_pl = 1'b1; end
         KEY_6: if (!key_ext && HAS_P1) begin key_fn = KeyCoin;   key_pl = 1'b1; end
         default: key_fn = KeyNone;
      endcase
   end

   always_comb begin
      key_d = key_q;
      if (key_event) begin
         case (key_fn)
            KeyUp:     key_d[key_pl].u       = key_pressed;
            KeyDown:   key_d[key_pl].d       = key_pressed;
            KeyLeft:   key_d[key_pl].l       = key_pressed;
            KeyRight:  key_d[key_pl].r       = key_pressed;
            KeyFireA:  key_d[key_pl].fire_a  = key_pressed;
            KeyFireB:  key_d[key_pl].fire_b  = key_pressed;
            KeyStartA: key_d[key_pl].start_a = key_pressed;
            KeyStartB: key_d[key_pl].start_b = key_pressed;
            KeyCoin:   key_d[key_pl].coin    = key_pressed;
            default:   key_d = key_q;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         shadow_q <= 1'b0;
         key_q    <= '0;
      end else begin
         shadow_q <= ps2_key[10];
         key_q    <= key_d;
      end
   end

   // Raw state is taken from the latch's next value so the output register is the only
   // stage between a PS/2 event and the cabinet pins.
   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      logic [15:0] joy;
      logic [3:0]  dirs_raw;
      logic        start_raw;
      logic        unused_joy;

      assign joy        = joystick[16*p +: 16];
      assign unused_joy = ^joy[15:7];
      assign dirs_raw   = {key_d[p].r, key_d[p].l, key_d[p].d, key_d[p].u}
                        | {joy[JOY_R], joy[JOY_L], joy[JOY_D], joy[JOY_U]};
      assign start_raw  = key_d[p].start_a | key_d[p].start_b | joy[JOY_START];

      assign dirs_next[4*p +: 4] = rotate ? rotate_dirs(dirs_raw, CW_SENSE) : dirs_raw;
      assign fire_next[p]        = key_d[p].fire_a | key_d[p].fire_b | joy[JOY_FIRE];
      assign start_next[p]       = start_raw;
      assign coin_req[p]         = key_d[p].coin | joy[JOY_COIN]
                                 | ((START_IS_COIN != 0) & start_raw);

      input_pulse_stretch #(
         .CYCLES (COIN_PULSE_CYCLES)
      ) u_coin (
         .clk_sys (clk_sys),
         .reset   (reset),
         .req     (coin_req[p]),
         .pulse   (coin_pulse[p])
      );
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dirs_q  <= '0;
         fire_q  <= '0;
         start_q <= '0;
      end else begin
         dirs_q  <= dirs_next;
         fire_q  <= fire_next;
         start_q <= start_next;
      end
   end

   assign dirs_o  = dirs_q     ^ {(4*NUM_PLAYERS){POL}};
   assign fire_o  = fire_q     ^ {NUM_PLAYERS{POL}};
   assign start_o = start_q    ^ {NUM_PLAYERS{POL}};
   assign coin_o  = coin_pulse ^ {NUM_PLAYERS{POL}};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: two instances differing only in rotation sense,
// active-low outputs, 5-cycle coin pulses.
module tb_arcade_input_mapper;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [31:0] joystick;
   logic        rotate;
   logic        tog;

   logic [7:0] dirs_a, dirs_b;
   logic [1:0] fire_a, start_a, coin_a;
   logic [1:0] fire_b, start_b, coin_b;

   int tests = 0;
   int fails = 0;
   int low;

   always #5 clk_sys = ~clk_sys;

   arcade_input_mapper #(
      .NUM_PLAYERS       (2),
      .COIN_PULSE_CYCLES (5),
      .ACTIVE_LOW        (1),
      .START_IS_COIN     (1),
      .ROT_CW            (0)
   ) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ps2_key  (ps2_key),
      .joystick (joystick),
      .rotate   (rotate),
      .dirs_o   (dirs_a),
      .fire_o   (fire_a),
      .start_o  (start_a),
      .coin_o   (coin_a)
   );

   arcade_input_mapper #(
      .NUM_PLAYERS       (2),
      .COIN_PULSE_CYCLES (5),
      .ACTIVE_LOW        (1),
      .START_IS_COIN     (1),
      .ROT_CW            (1)
   ) dut_cw (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ps2_key  (ps2_key),
      .joystick (joystick),
      .rotate   (rotate),
      .dirs_o   (dirs_b),
      .fire_o   (fire_b),
      .start_o  (start_b),
      .coin_o   (coin_b)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
      tog = ~tog;
      ps2_key = {tog, pressed, ext, code};
      step(1);
   endtask

   initial begin
      reset = 1'b1;
      ps2_key = '0;
      joystick = '0;
      rotate = 1'b0;
      tog = 1'b0;
      step(2);
      check("reset_dirs", dirs_a, 8'hFF);
      check("reset_fire", {6'd0, fire_a}, 8'h03);
      check("reset_start", {6'd0, start_a}, 8'h03);
      check("reset_coin", {6'd0, coin_a}, 8'h03);
      reset = 1'b0;
      step(2);
      check("idle_dirs", dirs_a, 8'hFF);
      check("idle_coin", {6'd0, coin_a}, 8'h03);

      key(1'b1, 1'b0, 8'h75);
      check("p0_up_press", dirs_a, 8'hFE);
      key(1'b0, 1'b0, 8'h75);
      check("p0_up_release", dirs_a, 8'hFF);
      key(1'b1, 1'b1, 8'h6B);
      check("p0_left_ext", dirs_a, 8'hFB);
      key(1'b0, 1'b1, 8'h6B);
      check("p0_left_ext_rel", dirs_a, 8'hFF);
      key(1'b1, 1'b1, 8'h29);
      check("space_ext_ignored", {6'd0, fire_a}, 8'h03);
      key(1'b0, 1'b1, 8'h29);

      rotate = 1'b1;
      key(1'b1, 1'b0, 8'h6B);
      check("rot_ccw_left_to_up", dirs_a, 8'hFE);
      check("rot_cw_left_to_down", dirs_b, 8'hFD);
      rotate = 1'b0;
      step(1);
      check("rot_off_left", dirs_a, 8'hFB);
      key(1'b0, 1'b0, 8'h6B);
      check("rot_left_release", dirs_a, 8'hFF);

      key(1'b1, 1'b0, 8'h29);
      check("fire_space", {6'd0, fire_a}, 8'h02);
      key(1'b1, 1'b0, 8'h14);
      check("fire_both", {6'd0, fire_a}, 8'h02);
      key(1'b0, 1'b0, 8'h29);
      check("fire_ctrl_holds", {6'd0, fire_a}, 8'h02);
      key(1'b0, 1'b0, 8'h14);
      check("fire_released", {6'd0, fire_a}, 8'h03);
      joystick[20] = 1'b1;
      step(1);
      check("p1_joy_fire", {6'd0, fire_a}, 8'h01);
      joystick[20] = 1'b0;
      step(1);
      key(1'b1, 1'b0, 8'h1C);
      check("p1_key_fire", {6'd0, fire_a}, 8'h01);
      key(1'b0, 1'b0, 8'h1C);
      key(1'b1, 1'b0, 8'h2D);
      check("p1_up_key", dirs_a, 8'hEF);
      key(1'b0, 1'b0, 8'h2D);
      check("p1_up_release", dirs_a, 8'hFF);

      // Held coin key: pulse width must be exactly five cycles.
      low = 0;
      key(1'b1, 1'b0, 8'h2E);
      for (int i = 0; i < 20; i++) begin
         if (coin_a[0] == 1'b0) low++;
         step(1);
      end
      check("coin_width", 8'(low), 8'd5);
      check("coin_after_hold", {6'd0, coin_a}, 8'h03);
      key(1'b0, 1'b0, 8'h2E);
      step(2);

      // Re-press on the third pulse cycle must not extend the pulse.
      low = 0;
      key(1'b1, 1'b0, 8'h2E);
      if (coin_a[0] == 1'b0) low++;
      key(1'b0, 1'b0, 8'h2E);
      if (coin_a[0] == 1'b0) low++;
      key(1'b1, 1'b0, 8'h2E);
      if (coin_a[0] == 1'b0) low++;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (coin_a[0] == 1'b0) low++;
      end
      check("coin_no_extend", 8'(low), 8'd5);
      key(1'b0, 1'b0, 8'h2E);
      step(2);

      joystick[5] = 1'b1;
      step(1);
      check("start_joy", {6'd0, start_a}, 8'h02);
      check("start_coin", {6'd0, coin_a}, 8'h02);
      step(5);
      check("start_coin_end", {6'd0, coin_a}, 8'h03);
      check("start_still_held", {6'd0, start_a}, 8'h02);
      joystick[5] = 1'b0;
      step(1);
      check("start_released", {6'd0, start_a}, 8'h03);

      joystick[6] = 1'b1;
      joystick[22] = 1'b1;
      step(1);
      check("coin_both_start", {6'd0, coin_a}, 8'h00);
      step(4);
      check("coin_both_mid", {6'd0, coin_a}, 8'h00);
      step(1);
      check("coin_both_end", {6'd0, coin_a}, 8'h03);
      joystick = '0;
      step(2);

      key(1'b1, 1'b0, 8'h75);
      key(1'b1, 1'b0, 8'h2E);
      check("pre_reset_dirs", dirs_a, 8'hFE);
      check("pre_reset_coin", {6'd0, coin_a}, 8'h02);
      step(1);
      reset = 1'b1;
      #1;
      check("async_reset_dirs", dirs_a, 8'hFF);
      check("async_reset_coin", {6'd0, coin_a}, 8'h03);
      tog = 1'b0;
      ps2_key = '0;
      step(2);
      reset = 1'b0;
      low = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (coin_a[0] == 1'b0) low++;
      end
      check("no_coin_after_reset", 8'(low), 8'd0);
      check("keys_cleared", dirs_a, 8'hFF);
      key(1'b1, 1'b0, 8'h2E);
      check("fresh_coin_edge", {6'd0, coin_a}, 8'h02);
      key(1'b0, 1'b0, 8'h2E);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
